pixel_stream_proc: RTL and testbench

- Synthesizable, parametrised pixel-stream processor: the hardware successor to the testbench-side invert loop.
- Takes a frame of packed multi-channel pixels over a valid/ready stream and applies a selectable per-frame operation: pass, invert, grayscale or threshold.
- Emits the result with start/end-of-line and start/end-of-frame markers.
- Sits between the BMP DPI pixel source/sink in the bench and, later, real video datapaths.

---
 rtl/pixel_stream_proc.sv | 202 ++++++++++++++++++++
 tb/tb_pixel_stream_proc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: frame-based pixel stream processor.
// Accepts packed multi-channel pixels over valid/ready and applies a per-frame
// operation (pass, invert, grayscale, threshold). Output pixels carry
// start/end-of-line and start/end-of-frame markers. Two pipeline stages share
// a single enable, so a stalled output freezes the whole pipe with no bubbles.
module pixel_stream_proc #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIM_WIDTH-1:0]           cfg_width,
  input  logic [DIM_WIDTH-1:0]           cfg_height,
  input  logic [1:0]                     cfg_mode,
  input  logic [DATA_WIDTH-1:0]          cfg_threshold,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
  output logic                           m_sof,
  output logic                           m_eof,
  output logic                           m_sol,
  output logic                           m_eol
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg;
  logic [DIM_WIDTH-1:0]  width_reg, height_reg;
  logic [DIM_WIDTH-1:0]  col_reg, line_reg;
  logic [1:0]            mode_reg;
  logic [DATA_WIDTH-1:0] thr_reg;
  logic                  busy_reg, done_reg;

  // Stage 1: raw pixel, its gray level and the markers
  logic                  s1_valid_reg;
  logic [PW-1:0]         s1_data_reg;
  logic [DATA_WIDTH-1:0] s1_gray_reg;
  logic                  s1_sof_reg, s1_eof_reg, s1_sol_reg, s1_eol_reg;

  // Stage 2: output registers
  logic                  m_valid_reg;
  logic [PW-1:0]         m_data_reg;
  logic                  m_sof_reg, m_eof_reg, m_sol_reg, m_eol_reg;

  logic                  en, accept, out_hs;
  logic                  col_last, line_last;
  logic [DATA_WIDTH-1:0] gray_next;
  logic [PW-1:0]         out_next;
  logic                  thr_hit;

  assign en        = !m_valid_reg || m_ready;
  assign s_ready   = (state_reg == RUN) && en;
  assign accept    = s_valid && s_ready;
  assign out_hs    = m_valid_reg && m_ready;
  assign col_last  = (col_reg == width_reg - DIM_WIDTH'(1));
  assign line_last = (line_reg == height_reg - DIM_WIDTH'(1));
  assign thr_hit   = (s1_gray_reg >= thr_reg);

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_sof   = m_sof_reg;
  assign m_eof   = m_eof_reg;
  assign m_sol   = m_sol_reg;
  assign m_eol   = m_eol_reg;

  // Gray level: (c0 + 2*c1 + c2) / 4, falling back to c0 for 1- or 2-channel pixels
  generate
    if (CHANNELS >= 3) begin : g_gray3
      logic [DATA_WIDTH+1:0] gray_sum;
      assign gray_sum = {2'b00, s_data[0 +: DATA_WIDTH]}
                      + {1'b0, s_data[DATA_WIDTH +: DATA_WIDTH], 1'b0}
                      + {2'b00, s_data[2*DATA_WIDTH +: DATA_WIDTH]};
      assign gray_next = gray_sum[DATA_WIDTH+1:2];
    end else begin : g_gray1
      assign gray_next = s_data[0 +: DATA_WIDTH];
    end
  endgenerate

  // Per-channel output operation; an alpha channel (index 3) is never modified
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] ch_val, res_val;
      assign ch_val = s1_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      if (gi == 3) begin : g_alpha
        assign res_val = ch_val;
      end else begin : g_color
        // Select the channel result according to the latched frame mode
        always_comb begin
          res_val = ch_val;
          case (mode_reg)
            2'd1:    res_val = MAX - ch_val;
            2'd2:    res_val = s1_gray_reg;
            2'd3:    res_val = thr_hit ? MAX : '0;
            default: res_val = ch_val;
          endcase
        end
      end
      assign out_next[gi*DATA_WIDTH +: DATA_WIDTH] = res_val;
    end
  endgenerate

  // Frame control FSM: configuration latch, position counters, busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      width_reg  <= '0;
      height_reg <= '0;
      mode_reg   <= '0;
      thr_reg    <= '0;
      col_reg    <= '0;
      line_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            width_reg  <= cfg_width;
            height_reg <= cfg_height;
            mode_reg   <= cfg_mode;
            thr_reg    <= cfg_threshold;
            col_reg    <= '0;
            line_reg   <= '0;
            if (cfg_width == '0 || cfg_height == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (col_last) begin
              col_reg  <= '0;
              line_reg <= line_reg + DIM_WIDTH'(1);
              if (line_last) state_reg <= DRAIN;
            end else begin
              col_reg <= col_reg + DIM_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (out_hs && m_eof_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Two-stage datapath; both stages advance together on en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_gray_reg  <= '0;
      s1_sof_reg   <= 1'b0;
      s1_eof_reg   <= 1'b0;
      s1_sol_reg   <= 1'b0;
      s1_eol_reg   <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_sof_reg    <= 1'b0;
      m_eof_reg    <= 1'b0;
      m_sol_reg    <= 1'b0;
      m_eol_reg    <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= accept;
      s1_data_reg  <= s_data;
      s1_gray_reg  <= gray_next;
      s1_sof_reg   <= accept && (col_reg == '0) && (line_reg == '0);
      s1_eof_reg   <= accept && col_last && line_last;
      s1_sol_reg   <= accept && (col_reg == '0);
      s1_eol_reg   <= accept && col_last;
      m_valid_reg  <= s1_valid_reg;
      m_data_reg   <= out_next;
      m_sof_reg    <= s1_sof_reg;
      m_eof_reg    <= s1_eof_reg;
      m_sol_reg    <= s1_sol_reg;
      m_eol_reg    <= s1_eol_reg;
    end
  end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Testbench for pixel_stream_proc: randomized frames checked by a scoreboard.
module tb_pixel_stream_proc;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_width, cfg_height;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_threshold;
  logic        start;
  logic        busy, done;
  logic        s_valid, s_ready;
  logic [23:0] s_data;
  logic        m_valid, m_ready;
  logic [23:0] m_data;
  logic        m_sof, m_eof, m_sol, m_eol;

  pixel_stream_proc #(.DATA_WIDTH(8), .CHANNELS(3), .DIM_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mode(cfg_mode),
    .cfg_threshold(cfg_threshold), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof), .m_sol(m_sol), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        sof, eof, sol, eol;
    int          acc_cyc;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    out_cnt = 0;
  bit    bp_on = 0;
  bit    pending_done = 0;
  bit    prev_stall = 0;
  logic [27:0] prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the operation applied to a whole pixel, from channel arithmetic
  function automatic logic [23:0] model(input logic [23:0] px, input logic [1:0] mode,
                                        input logic [7:0] thr);
    int c0, c1, c2, g;
    logic [7:0] gb;
    c0 = int'(px[7:0]);
    c1 = int'(px[15:8]);
    c2 = int'(px[23:16]);
    g  = (c0 + 2 * c1 + c2) / 4;
    gb = 8'(g);
    case (mode)
      2'd0:    return px;
      2'd1:    return {8'(255 - c2), 8'(255 - c1), 8'(255 - c0)};
      2'd2:    return {gb, gb, gb};
      default: return (g >= int'(thr)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Downstream ready: always 1, or pseudo-random when backpressure is enabled
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (reset) begin
      prev_stall   = 0;
      pending_done = 0;
    end else begin
      if (pending_done) begin
        check("done_after_eof", {31'd0, done}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        pending_done = 0;
      end
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, m_valid}, 32'd1);
        check("stall_data_hold", {4'd0, m_data, m_sof, m_eof, m_sol, m_eol}, {4'd0, prev_out});
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_data, m_sof, m_eof, m_sol, m_eol};
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h required none", m_data);
        end else begin
          item_t it;
          it = sb.pop_front();
          $display("out #%0d data=%h sof=%0b eof=%0b sol=%0b eol=%0b", out_cnt, m_data,
                   m_sof, m_eof, m_sol, m_eol);
          check("out_data", {8'd0, m_data}, {8'd0, it.data});
          check("out_markers", {28'd0, m_sof, m_eof, m_sol, m_eol},
                {28'd0, it.sof, it.eof, it.sol, it.eol});
          if (!bp_on) check("latency", 32'(cyc - it.acc_cyc), 32'd2);
          if (m_eof) pending_done = 1;
        end
        out_cnt++;
      end
    end
  end

  task automatic pulse_start(input int w, input int h, input logic [1:0] mode,
                             input logic [7:0] thr);
    @(posedge clk);
    #1;
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    cfg_mode = mode;
    cfg_threshold = thr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Drive up to n_limit pixels of a w x h frame; push each accepted pixel's expectation
  task automatic run_frame(input int w, input int h, input logic [1:0] mode,
                           input logic [7:0] thr, input bit use_fixed,
                           input logic [23:0] fixed_px, input int n_limit);
    int n;
    pulse_start(w, h, mode, thr);
    n = w * h;
    if (n_limit < n) n = n_limit;
    for (int i = 0; i < n; i++) begin
      item_t it;
      logic [23:0] px;
      int t;
      px = (use_fixed && i == 0) ? fixed_px : 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data = px;
      t = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        t++;
        if (t > 2000) break;
      end
      if (t > 2000) begin
        check("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      it.data = model(px, mode, thr);
      it.sol = (i % w) == 0;
      it.eol = (i % w) == w - 1;
      it.sof = (i == 0);
      it.eof = (i == w * h - 1);
      it.acc_cyc = cyc;
      sb.push_back(it);
      $display("in  #%0d data=%h col=%0d line=%0d", i, px, i % w, i / w);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {21'd0, busy, done, s_ready, m_valid, m_sof, m_eof, m_sol, m_eol, 3'd0},
          32'd0);
    check({name, "_data"}, {8'd0, m_data}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cfg_width = 16'd0;
    cfg_height = 16'd0;
    cfg_mode = 2'd0;
    cfg_threshold = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4x2 invert frame starting with 0x102030
    bp_on = 0;
    run_frame(4, 2, 2'd1, 8'd0, 1, 24'h102030, 1000);
    wait_done();
    check("invert_ref", {8'd0, model(24'h102030, 2'd1, 8'd0)}, 32'h00EFDFCF);

    // Single-pixel frames: gray and threshold on either side of the gray level
    run_frame(1, 1, 2'd2, 8'd0, 1, 24'h4080C0, 1000);
    wait_done();
    run_frame(1, 1, 2'd3, 8'h81, 1, 24'h4080C0, 1000);
    wait_done();
    run_frame(1, 1, 2'd3, 8'h80, 1, 24'h4080C0, 1000);
    wait_done();

    // 16x16 pass-through under random backpressure
    bp_on = 1;
    run_frame(16, 16, 2'd0, 8'd0, 0, 24'd0, 1000);
    wait_done();

    // Random small frames in every mode
    for (int k = 0; k < 8; k++) begin
      bp_on = 1'($urandom_range(0, 1));
      run_frame($urandom_range(1, 6), $urandom_range(1, 5), 2'($urandom_range(0, 3)),
                8'($urandom), 0, 24'd0, 1000);
      wait_done();
    end
    bp_on = 0;
    @(posedge clk);
    #1;

    // Zero-width frame: immediate done, no output, never busy
    pulse_start(0, 5, 2'd0, 8'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("zero_quiet", {29'd0, busy, done, m_valid}, 32'd0);
    end

    // Reset after 5 of 8 pixels: everything clears, no done
    run_frame(4, 2, 2'd1, 8'd0, 0, 24'd0, 5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("reset_abort");
    sb.delete();
    repeat (2) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_idle", {30'd0, busy, done}, 32'd0);
    end
    run_frame(2, 2, 2'd2, 8'd0, 0, 24'd0, 1000);
    wait_done();

    // start pulsed mid-frame with a different mode and size is ignored
    fork
      run_frame(4, 4, 2'd1, 8'd0, 0, 24'd0, 1000);
      begin
        repeat (8) @(posedge clk);
        #2;
        cfg_mode = 2'd0;
        cfg_width = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
